// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M execution unit for the EX stage.
//
// All eight M-extension ops share one datapath: multiplies are an unsigned
// shift-add of operand magnitudes into a 2N-bit accumulator, divides are a
// restoring division of magnitudes. One bit is processed per cycle, then a
// FIX cycle applies signs and RISC-V special-case results.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_Start         M-type instruction present in EX
//   i_Funct3        op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_Read1/2       rs1 / rs2 operands (already forwarded)
//   i_Rd            destination register
//   i_Flush         abort the operation in flight
//   o_ctrl_EX_Busy  stall request to hazard detection
//   o_Done          one-cycle result-valid pulse
//   o_Result, o_Rd  registered result and its destination register
//
// Build option: define MULDIV_EARLY_OUT_EN to let divide-by-zero and signed
// overflow complete straight from IDLE (result in cycle 1).

module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic [2:0]            i_Funct3,
  input  logic [DATA_WIDTH-1:0] i_Read1,
  input  logic [DATA_WIDTH-1:0] i_Read2,
  input  logic [4:0]            i_Rd,
  input  logic                  i_Flush,
  output logic                  o_ctrl_EX_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic [4:0]            o_Rd
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [2:0]    funct3_reg;
  logic          neg_a_reg, neg_b_reg, special_reg;
  logic [N-1:0]  op_mag_reg;   // multiplicand (mul) or divisor (div)
  logic [N:0]    acc_hi_reg;   // product high half / partial remainder
  logic [N-1:0]  acc_lo_reg;   // multiplier bits (mul) or dividend->quotient (div)
  logic [N-1:0]  forced_reg;   // special-case result decided at accept
  logic [4:0]    rd_pend_reg;
  logic          done_reg;
  logic [N-1:0]  result_reg;
  logic [4:0]    rd_reg;

  // ---------------- accept-time decode ----------------
  logic         in_sign_a, in_sign_b, in_neg_a, in_neg_b;
  logic         in_is_div, in_div0, in_ovf, in_special;
  logic [N-1:0] in_mag_a, in_mag_b, in_forced;

  always_comb begin
    in_is_div = i_Funct3[2];
    in_sign_a = 1'b0;
    in_sign_b = 1'b0;
    case (i_Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        in_sign_a = 1'b1;
        in_sign_b = 1'b1;
      end
      3'b010:  in_sign_a = 1'b1;   // MULHSU: only rs1 is signed
      default: ;
    endcase
    in_neg_a   = in_sign_a & i_Read1[N-1];
    in_neg_b   = in_sign_b & i_Read2[N-1];
    in_mag_a   = in_neg_a ? -i_Read1 : i_Read1;
    in_mag_b   = in_neg_b ? -i_Read2 : i_Read2;
    in_div0    = in_is_div & (i_Read2 == '0);
    in_ovf     = in_is_div & ~i_Funct3[0] & (i_Read1 == MIN_NEG) & (&i_Read2);
    in_special = in_div0 | in_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (in_div0) in_forced = i_Funct3[1] ? i_Read1 : '1;
    else         in_forced = i_Funct3[1] ? '0 : i_Read1;
  end

  // ---------------- per-cycle datapath ----------------
  logic [N:0] mul_sum, div_shift, div_trial;

  always_comb begin
    // acc_hi_reg[N] is always 0 in multiply mode, so the full register can feed the adder.
    mul_sum   = acc_hi_reg + {1'b0, {N{acc_lo_reg[0]}} & op_mag_reg};
    div_shift = {acc_hi_reg[N-1:0], acc_lo_reg[N-1]};
    // Bit N of the trial set means the subtraction went negative: restore.
    div_trial = div_shift - {1'b0, op_mag_reg};
  end

  // ---------------- sign fix-up ----------------
  logic [2*N-1:0] product, prod_fix;
  logic [N-1:0]   quo, rem, fix_result;

  always_comb begin
    product  = {acc_hi_reg[N-1:0], acc_lo_reg};
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -product : product;
    quo      = acc_lo_reg;
    rem      = acc_hi_reg[N-1:0];
    if (special_reg)
      fix_result = forced_reg;
    else if (funct3_reg[2])
      fix_result = funct3_reg[1] ? (neg_a_reg ? -rem : rem)
                                 : ((neg_a_reg ^ neg_b_reg) ? -quo : quo);
    else if (funct3_reg[1:0] == 2'b00)
      fix_result = prod_fix[N-1:0];
    else
      fix_result = prod_fix[2*N-1:N];
  end

  // ---------------- control and state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      rd_reg      <= '0;
      funct3_reg  <= '0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      special_reg <= 1'b0;
      op_mag_reg  <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      forced_reg  <= '0;
      rd_pend_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_Start && !i_Flush) begin
            funct3_reg  <= i_Funct3;
            rd_pend_reg <= i_Rd;
            neg_a_reg   <= in_neg_a;
            neg_b_reg   <= in_neg_b;
            special_reg <= in_special;
            forced_reg  <= in_forced;
            count_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= in_is_div ? in_mag_a : in_mag_b;
            op_mag_reg  <= in_is_div ? in_mag_b : in_mag_a;
`ifdef MULDIV_EARLY_OUT_EN
            if (in_special) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= in_forced;
              rd_reg     <= i_Rd;
            end else begin
              state_reg <= CALC;
            end
`else
            state_reg <= CALC;
`endif
          end
        end
        CALC: begin
          if (i_Flush) begin
            state_reg <= IDLE;
            count_reg <= '0;
          end else begin
            if (funct3_reg[2]) begin
              acc_lo_reg <= {acc_lo_reg[N-2:0], ~div_trial[N]};
              acc_hi_reg <= div_trial[N] ? div_shift : div_trial;
            end else begin
              acc_hi_reg <= {1'b0, mul_sum[N:1]};
              acc_lo_reg <= {mul_sum[0], acc_lo_reg[N-1:1]};
            end
            if (count_reg == LAST) begin
              count_reg <= '0;
              state_reg <= FIX;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        FIX: begin
          if (i_Flush) begin
            state_reg <= IDLE;
          end else begin
            result_reg <= fix_result;
            rd_reg     <= rd_pend_reg;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Busy drops in DONE so the pipeline advances and captures the result.
  assign o_ctrl_EX_Busy = ((state_reg == IDLE) && i_Start) ||
                          (state_reg == CALC) || (state_reg == FIX);
  assign o_Done   = done_reg;
  assign o_Result = result_reg;
  assign o_Rd     = rd_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative M-extension execution unit in the EX stage.
- Consumes the decoded operands and funct3 that the decode stage places in ID/EX.
- Returns the busy/stall indication the hazard logic uses to hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Performs all eight RV32M ops with a shared shift-add / restoring-divide datapath, one bit per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width N; iteration count equals N.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
i_Start  input  1  M-type instruction present in EX (opcode OP, funct7=0000001)
i_Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_Read1  input  DATA_WIDTH  rs1 operand (already forwarded)
i_Read2  input  DATA_WIDTH  rs2 operand (already forwarded)
i_Rd  input  5  destination register
i_Flush  input  1  abort current operation
o_ctrl_EX_Busy  output  1  stall request to hazard detection
o_Done  output  1  result valid, one-cycle pulse
o_Result  output  DATA_WIDTH  registered result
o_Rd  output  5  rd latched at accept

Behaviour:
- Reset (synchronous, highest priority):
  - State goes to IDLE.
  - o_Done=0, o_Result=0, o_Rd=0, counter=0.
  - o_ctrl_EX_Busy=0 in the following cycle.
  - Applies mid-operation too; the operation is discarded.
- States and transitions:
  - IDLE -> CALC when i_Start=1.
  - CALC runs N cycles (counter 0..N-1), then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Accept (IDLE & i_Start): latch funct3, i_Rd, operand signs, operand magnitudes and special-case flags.
  - Signedness per operand: MULH both; MULHSU rs1 only; MULHU/DIVU/REMU none; MUL/DIV/REM both.
- o_ctrl_EX_Busy:
  - Combinational: (IDLE & i_Start) | CALC | FIX.
  - Low in DONE so the pipeline advances and captures the result.
- Latency: accept cycle = cycle 0.
  - Busy is high in cycles 0..N+1.
  - o_Done=1 in cycle N+2 only (34 for N=32).
- i_Start while in DONE is ignored; it is the same instruction leaving EX. A new op can be accepted only from IDLE.
- Multiply: unsigned shift-add of magnitudes into a 2N-bit accumulator, one multiplier bit per CALC cycle.
  - FIX negates the 2N-bit product when the result sign is negative.
  - MUL selects [N-1:0]; MULH/MULHSU/MULHU select [2N-1:N].
- Divide: restoring division of magnitudes, one quotient bit per cycle; the remainder register is N+1 bits.
  - FIX negates the quotient if the operand signs differ (signed ops only).
  - FIX gives the remainder the sign of the dividend.
- Special cases (result forced in FIX, per RISC-V):
  - Divisor=0: DIV/DIVU result all ones; REM/REMU result = dividend.
  - Signed overflow (dividend=100..0, divisor=all ones): DIV result = dividend; REM result = 0.
- o_Result and o_Rd are written on the FIX->DONE edge and held until the next accept or reset.
- i_Flush in CALC/FIX: next state is IDLE, no o_Done, o_Result unchanged.
  - Busy drops the next cycle.
  - Flush in IDLE/DONE has no effect.
  - i_Flush has priority over i_Start in the same cycle: no accept.
- Simultaneous rst and i_Flush: reset behaviour.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: at accept, divide-by-zero and signed-overflow cases skip CALC and FIX and go IDLE -> DONE.
  - Busy is high in cycle 0 only; o_Done and the forced result appear in cycle 1.
- Undefined: these cases take the full N+2 latency, with the result forced in FIX.
- Normal ops have the same latency in both builds.

Test Plan:
1. MUL, i_Read1=7, i_Read2=0xFFFFFFFD -> Busy cycles 0..33; o_Done at cycle 34; o_Result=0xFFFFFFEB; o_Rd=i_Rd.
2. i_Read1=i_Read2=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF; MUL 0x00000001.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
   - o_Done at cycle 1 with MULDIV_EARLY_OUT_EN, at cycle 34 without.
5. i_Flush at cycle 10 of a DIVU -> Busy 0 from cycle 11; no o_Done; o_Result keeps its prior value; a new MUL accepted at cycle 12 completes at 12+34.
6. rst at cycle 20 of a MULH -> cycle 21 all outputs 0 and IDLE; separately, i_Start held high through DONE -> only one o_Done pulse, re-accept only after IDLE.
